vocab_matcher: RTL and testbench

//  Parametrised vocabulary matcher: compares one packed input word against a

---
 rtl/vocab_matcher.sv | 141 ++++++++++++++
 tb/tb_vocab_matcher.sv | 131 +++++++++++++
 2 files changed

// File: rtl/vocab_matcher.sv
// vocab_matcher: matches a packed input word against zero-terminated vocab entries in a sync-read SRAM
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           search request (IDLE only), synchronous abort
//   word                   input word, char i at [i*DATA_WIDTH +: DATA_WIDTH], 0-terminated
//   start_addr, end_addr   first / last (inclusive) vocab address, sampled on start
//   mem_rd_en, mem_addr    SRAM read port, data returns on mem_rdata one cycle later
//   busy, done             search in progress, one-cycle end-of-search pulse
//   found, token_id        hit flag and matching entry index, held after done
//   match_addr             start address of the matching entry, held after done
module vocab_matcher #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_WORD_LEN = 8,
    parameter int ID_WIDTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word,
    input  logic [ADDR_WIDTH-1:0]              start_addr,
    input  logic [ADDR_WIDTH-1:0]              end_addr,
    output logic                               mem_rd_en,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    input  logic [DATA_WIDTH-1:0]              mem_rdata,
    output logic                               busy,
    output logic                               done,
    output logic                               found,
    output logic [ID_WIDTH-1:0]                token_id,
    output logic [ADDR_WIDTH-1:0]              match_addr
);
    localparam int CI_W = $clog2(MAX_WORD_LEN + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, CHECK, FIN} state_t;
    state_t                             state;
    logic                               skip;
    logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word_l;
    logic [ADDR_WIDTH-1:0]              av, end_l, entry, av_n, entry_n;
    logic [CI_W-1:0]                    ci;
    logic [ID_WIDTH-1:0]                tok, tok_n;
    logic [MAX_WORD_LEN*DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0]              in_char;
    logic                               term, eq, dbl, hit, adv, stop;
    always_comb begin
        sh      = word_l >> (ci * DATA_WIDTH);
        // past the last slot the word reads as its implicit terminator
        in_char = (ci < CI_W'(MAX_WORD_LEN)) ? sh[DATA_WIDTH-1:0] : '0;
        term    = mem_rdata == '0;
        eq      = mem_rdata == in_char;
        // terminator right at an entry start marks the end of the vocabulary
        dbl     = !skip && term && ci == '0;
        hit     = !skip && eq && term;
        // a terminator that is neither a hit nor end-of-vocab moves to the next entry
        adv     = term && !dbl && !hit;
        av_n    = av + 1'b1;
        tok_n   = adv ? tok + 1'b1 : tok;
        entry_n = adv ? av_n : entry;
        stop    = dbl || av == end_l;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            skip       <= 1'b0;
            word_l     <= '0;
            av         <= '0;
            end_l      <= '0;
            entry      <= '0;
            ci         <= '0;
            tok        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            token_id   <= '0;
            match_addr <= '0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    word_l     <= word;
                    end_l      <= end_addr;
                    av         <= start_addr;
                    entry      <= start_addr;
                    ci         <= '0;
                    tok        <= '0;
                    skip       <= 1'b0;
                    found      <= 1'b0;
                    token_id   <= '0;
                    match_addr <= '0;
                    busy       <= 1'b1;
                    if (word[DATA_WIDTH-1:0] == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= start_addr;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_rd_en <= 1'b0;
                    state     <= CHECK;
                end
                CHECK: if (hit) begin
                    found      <= 1'b1;
                    token_id   <= tok;
                    match_addr <= entry;
                    done       <= 1'b1;
                    state      <= FIN;
                end else begin
                    av    <= av_n;
                    tok   <= tok_n;
                    entry <= entry_n;
                    ci    <= adv ? '0 : (!skip && eq) ? ci + 1'b1 : ci;
                    skip  <= skip ? !term : !eq && !term;
                    if (stop) begin
                        token_id   <= tok_n;
                        match_addr <= entry_n;
                        done       <= 1'b1;
                        state      <= FIN;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= av_n;
                        state     <= ISSUE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vocab_matcher.sv
// tb_vocab_matcher: directed vectors for vocab_matcher against a sync-read SRAM model
module tb_vocab_matcher;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [63:0] word;
    logic [7:0]  start_addr, end_addr, mem_addr, mem_rdata, token_id, match_addr;
    logic        mem_rd_en, busy, done, found;
    logic [7:0]  mem [256];
    int          n_vec = 0;
    int          n_bad = 0;
    vocab_matcher dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word(word),
        .start_addr(start_addr), .end_addr(end_addr), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .found(found), .token_id(token_id), .match_addr(match_addr)
    );
    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] pack(input string s);
        logic [63:0] w = '0;
        for (int i = 0; i < s.len() && i < 8; i++) w[i*8 +: 8] = s[i];
        return w;
    endfunction
    task automatic put(input int a, input string s);
        for (int i = 0; i < s.len(); i++) mem[(a + i) % 256] = s[i];
    endtask
    task automatic run(input string t, input string s, input logic [7:0] sa, input logic [7:0] ea,
                       input int n, input logic fnd, input logic [7:0] tid, input logic [7:0] ma,
                       input logic [7:0] last, input bit inj);
        int k = 0;
        int reads = 0;
        logic [7:0] la = 8'h0;
        @(negedge clk);
        start = 1'b1; word = pack(s); start_addr = sa; end_addr = ea;
        @(posedge clk); #1;
        start = 1'b0;
        chk({t, ".busy"}, busy, 1'b1);
        while (!done && k < 300) begin
            if (mem_rd_en) begin reads++; la = mem_addr; end
            if (inj && k == 3) begin start = 1'b1; word = pack("cat"); start_addr = 8'd0; end
            else start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk({t, ".done_seen"}, done, 1'b1);
        chk({t, ".latency"}, k + 1, 2 * n + 1);
        chk({t, ".reads"}, reads, n);
        chk({t, ".last_addr"}, la, last);
        chk({t, ".found"}, found, fnd);
        chk({t, ".token_id"}, token_id, tid);
        chk({t, ".match_addr"}, match_addr, ma);
        @(posedge clk); #1;
        chk({t, ".done_pulse"}, done, 1'b0);
        chk({t, ".busy_after"}, busy, 1'b0);
        chk({t, ".held_found"}, found, fnd);
    endtask
    task automatic no_done(input string t, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            seen |= done | busy;
        end
        chk({t, ".quiet"}, seen, 1'b0);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h0;
        put(0, "cat");
        put(4, "dog");
        put(8, "do");
        put(16, "abcdefgh");
        mem[254] = "q";
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; word = '0; start_addr = '0; end_addr = '0;
        #12;
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.found", found, 1'b0);
        chk("rst.token_id", token_id, 8'd0);
        chk("rst.match_addr", match_addr, 8'd0);
        chk("rst.rd_en", mem_rd_en, 1'b0);
        chk("rst.mem_addr", mem_addr, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        run("dog",   "dog",      8'd0,   8'd15, 8,  1'b1, 8'd1, 8'd4,  8'd7,   1'b0);
        run("do",    "do",       8'd0,   8'd15, 11, 1'b1, 8'd2, 8'd8,  8'd10,  1'b0);
        run("dot",   "dot",      8'd0,   8'd15, 12, 1'b0, 8'd3, 8'd11, 8'd11,  1'b0);
        run("bound", "dog",      8'd0,   8'd5,  6,  1'b0, 8'd1, 8'd4,  8'd5,   1'b0);
        run("empty", "",         8'd0,   8'd15, 0,  1'b0, 8'd0, 8'd0,  8'd0,   1'b0);
        run("full",  "abcdefgh", 8'd16,  8'd31, 9,  1'b1, 8'd0, 8'd16, 8'd24,  1'b0);
        run("wrap",  "cat",      8'd254, 8'd3,  6,  1'b1, 8'd1, 8'd0,  8'd3,   1'b0);
        run("ign",   "dog",      8'd0,   8'd15, 8,  1'b1, 8'd1, 8'd4,  8'd7,   1'b1);
        @(negedge clk);
        start = 1'b1; word = pack("dot"); start_addr = 8'd0; end_addr = 8'd15;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.rd_en", mem_rd_en, 1'b0);
        no_done("abort", 30);
        run("do2",   "do",       8'd0,   8'd15, 11, 1'b1, 8'd2, 8'd8,  8'd10,  1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_idle.found", found, 1'b0);
        chk("rst_idle.token_id", token_id, 8'd0);
        chk("rst_idle.match_addr", match_addr, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        start = 1'b1; word = pack("dog"); start_addr = 8'd0; end_addr = 8'd15;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid.busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.busy", busy, 1'b0);
        chk("mid.rd_en", mem_rd_en, 1'b0);
        chk("mid.mem_addr", mem_addr, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        no_done("mid", 30);
        chk("mid.found", found, 1'b0);
        chk("mid.token_id", token_id, 8'd0);
        run("after", "dog",      8'd0,   8'd15, 8,  1'b1, 8'd1, 8'd4,  8'd7,   1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
